// File: rtl/audio_pkg.sv
// Shared widths and helpers for the stereo gain stage.
package audio_pkg;

    localparam int SAMPLE_W = 24;
    localparam int GAIN_W   = 8;

    // Target gain seen by the ramp: mute and negative requests both mean silence.
    function automatic logic [GAIN_W-1:0] clamp_gain(
        input logic signed [31:0] g,
        input logic               mute,
        input int                 gain_max
    );
        if (mute || g < 0) begin
            return '0;
        end else if (g > gain_max) begin
            return GAIN_W'(gain_max);
        end else begin
            return g[GAIN_W-1:0];
        end
    endfunction

    // Saturate a sign-extended product to a w-bit signed range (w <= 32).
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] x,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Applied-gain slew: steps cur_gain by +/-1 toward the clamped target every RAMP_DIV accepted frames.
module gain_ramp
    import audio_pkg::*;
#(
    parameter int GAIN_MAX  = 50,
    parameter int GAIN_INIT = 1,
    parameter int RAMP_DIV  = 64
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic signed [31:0]   gain,
    input  logic                 mute,
    input  logic                 step,
    output logic [GAIN_W-1:0]    cur_gain
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic [GAIN_W-1:0] target_gain;
    logic [GAIN_W-1:0] cur_gain_q, cur_gain_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    assign target_gain = clamp_gain(gain, mute, GAIN_MAX);

    // A target change mid-ramp keeps the partial frame count.
    always_comb begin
        cur_gain_d  = cur_gain_q;
        frame_cnt_d = frame_cnt_q;
        if (step) begin
            if (cur_gain_q == target_gain) begin
                frame_cnt_d = '0;
            end else if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                cur_gain_d  = (target_gain > cur_gain_q) ? cur_gain_q + 8'd1
                                                         : cur_gain_q - 8'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur_gain_q  <= GAIN_W'(GAIN_INIT);
            frame_cnt_q <= '0;
        end else begin
            cur_gain_q  <= cur_gain_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cur_gain = cur_gain_q;

endmodule

// File: rtl/gain_stage.sv
// Stereo gain stage: two-stage valid/ready pipeline (multiply, then saturate) driven by a slewed gain.
module gain_stage
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
    parameter int GAIN_MAX  = 50,
    parameter int GAIN_INIT = 1,
    parameter int RAMP_DIV  = 64
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic signed [31:0]         gain,
    input  logic                       mute,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_l,
    input  logic signed [SAMPLE_W-1:0] in_r,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_l,
    output logic signed [SAMPLE_W-1:0] out_r,
    output logic                       clip,
    output logic [GAIN_W-1:0]          cur_gain
);

    // Largest product |min_sample| * 255 fits in SAMPLE_W+GAIN_W signed bits.
    localparam int PROD_W = SAMPLE_W + GAIN_W;

    logic                       adv;
    logic                       accept;
    logic signed [PROD_W-1:0]   gain_ext;

    logic                       s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0]   s1_l_q, s1_l_d;
    logic signed [PROD_W-1:0]   s1_r_q, s1_r_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [SAMPLE_W-1:0] out_l_q, out_l_d;
    logic signed [SAMPLE_W-1:0] out_r_q, out_r_d;
    logic                       clip_q, clip_d;

    assign adv    = !out_valid_q || out_ready;
    assign accept = in_valid && adv;

    gain_ramp #(
        .GAIN_MAX  (GAIN_MAX),
        .GAIN_INIT (GAIN_INIT),
        .RAMP_DIV  (RAMP_DIV)
    ) u_gain_ramp (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .gain     (gain),
        .mute     (mute),
        .step     (accept),
        .cur_gain (cur_gain)
    );

    assign gain_ext = PROD_W'($signed({1'b0, cur_gain}));

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_l_d      = s1_l_q;
        s1_r_d      = s1_r_q;
        out_valid_d = out_valid_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        clip_d      = clip_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_l_d      = PROD_W'(in_l) * gain_ext;
            s1_r_d      = PROD_W'(in_r) * gain_ext;
            out_valid_d = s1_valid_q;
            out_l_d     = SAMPLE_W'(sat(64'(s1_l_q), SAMPLE_W));
            out_r_d     = SAMPLE_W'(sat(64'(s1_r_q), SAMPLE_W));
            clip_d      = s1_valid_q &&
                          ((sat(64'(s1_l_q), SAMPLE_W) != 64'(s1_l_q)) ||
                           (sat(64'(s1_r_q), SAMPLE_W) != 64'(s1_r_q)));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_q  <= 1'b0;
            s1_l_q      <= '0;
            s1_r_q      <= '0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            clip_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_l_q      <= s1_l_d;
            s1_r_q      <= s1_r_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            clip_q      <= clip_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_gain_stage.sv
// Scoreboard bench for gain_stage with RAMP_DIV=4 and an independent ramp/saturation model.
module tb_gain_stage;

    localparam int SW       = 24;
    localparam int GMAX     = 50;
    localparam int GINIT    = 1;
    localparam int RDIV     = 4;
    localparam longint SMAX = (longint'(1) <<< (SW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (SW - 1));

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic signed [31:0]   gain;
    logic                 mute;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [SW-1:0] in_l, in_r;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [SW-1:0] out_l, out_r;
    logic                 clip;
    logic [7:0]           cur_gain;

    gain_stage #(
        .SAMPLE_W  (SW),
        .GAIN_MAX  (GMAX),
        .GAIN_INIT (GINIT),
        .RAMP_DIV  (RDIV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .gain      (gain),
        .mute      (mute),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_l      (in_l),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
        .clip      (clip),
        .cur_gain  (cur_gain)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint l;
        longint r;
        bit     clip;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_gain;
    int   m_cnt;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_target();
        if (mute || gain < 0) return 0;
        if (gain > GMAX) return GMAX;
        return gain;
    endfunction

    function automatic longint sat_ref(input longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    task automatic model_accept();
        exp_t   e;
        longint pl, pr;
        int     t;
        pl = longint'(in_l) * m_gain;
        pr = longint'(in_r) * m_gain;
        e.l = sat_ref(pl);
        e.r = sat_ref(pr);
        e.clip = (e.l != pl) || (e.r != pr);
        q.push_back(e);
        t = model_target();
        if (m_gain == t) begin
            m_cnt = 0;
        end else if (m_cnt == RDIV - 1) begin
            m_gain = m_gain + ((t > m_gain) ? 1 : -1);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // One clock: settle inputs, score handshakes, advance, check the applied gain.
    task automatic step();
        bit   acc, fire;
        exp_t e;
        #1;
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        if (fire) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_l", out_l, e.l);
                chk("out_r", out_r, e.r);
                chk("clip", clip, e.clip);
            end
        end
        if (acc) model_accept();
        @(posedge CLK);
        #1;
        chk("cur_gain", cur_gain, m_gain);
    endtask

    task automatic do_reset(input int cycles);
        RST_N = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
        end
        #1;
        q.delete();
        m_gain = GINIT;
        m_cnt  = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_l", out_l, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_clip", clip, 0);
        chk("rst_cur_gain", cur_gain, GINIT);
        RST_N = 1'b1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_l = SW'($urandom);
            in_r = SW'($urandom);
            step();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        gain = 32'sd1; mute = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_l = '0; in_r = '0;
        do_reset(2);

        // basic pass-through at gain 1 with latency check
        in_valid = 1'b1; in_l = 24'sd1000; in_r = -24'sd1000;
        step();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", out_valid, 0);
        step();
        chk("lat_cycle2_valid", out_valid, 1);
        chk("t1_out_l", out_l, 1000);
        chk("t1_out_r", out_r, -1000);
        drain();

        // ramp 1 -> 5, stepping every 4 frames
        gain = 32'sd5;
        for (int i = 0; i < 20; i++) begin
            stream(1);
            if (i % 4 == 3) chk("ramp_up", cur_gain, (i / 4 + 2 > 5) ? 5 : i / 4 + 2);
        end
        drain();

        // out-of-range gain clamps to 50, then full-scale samples saturate
        gain = 32'sd200;
        stream(45 * RDIV + 2);
        chk("gain_clamped_50", cur_gain, 50);
        in_valid = 1'b1; in_l = 24'sh7FFFFF; in_r = 24'sh800000;
        step();
        in_valid = 1'b0;
        step();
        chk("sat_out_l", out_l, SMAX);
        chk("sat_out_r", out_r, SMIN);
        chk("sat_clip", clip, 1);
        drain();

        // back-pressure: hold five cycles with a full pipe
        stream(4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_l = SW'($urandom);
            step();
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            if (q.size() > 0) chk("stall_out_l_stable", out_l, q[0].l);
            else chk("stall_queue_nonempty", 0, 1);
        end
        out_ready = 1'b1;
        stream(3);
        drain();

        // ramp down to 3, then mute ramps 2,1,0; negative gain keeps target at 0
        gain = 32'sd3;
        stream(47 * RDIV + 2);
        chk("at_gain_3", cur_gain, 3);
        mute = 1'b1;
        stream(3 * RDIV + 2);
        chk("muted_gain_0", cur_gain, 0);
        mute = 1'b0; gain = -32'sd7;
        stream(8);
        chk("neg_gain_0", cur_gain, 0);
        drain();

        // reset mid-stream drops in-flight frames and restores initial gain
        gain = 32'sd9;
        stream(6);
        in_valid = 1'b1;
        do_reset(1);
        stream(10);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
